// File: rtl/spi_pkg.sv
// Shared types and defaults for the SPI target-side shift engine.
//   DATA_W_DEF  : default frame width
//   IDLE_TX_DEF : byte shifted out when the transmit buffer is empty
//   edge_t      : edge classification produced by spi_sync_edge
//   state_t     : frame FSM encoding (IDLE, ACTIVE)
package spi_pkg;

   localparam int         DATA_W_DEF  = 8;
   localparam logic [7:0] IDLE_TX_DEF = 8'h00;

   typedef enum logic [1:0] {
      EDGE_NONE = 2'b00,
      EDGE_RISE = 2'b01,
      EDGE_FALL = 2'b10
   } edge_t;

   typedef enum logic {
      IDLE   = 1'b0,
      ACTIVE = 1'b1
   } state_t;

endpackage

// File: rtl/spi_slave_shift_if.sv
// Bus bundle for spi_slave_shift: SPI pins plus the register-side
// transmit/receive handshake.
//   slave  modport : view of the shift engine
//   master modport : view of whoever drives the pins / register side
// With SPI_SLV_OVERRUN_EN defined, rx_ack (in) and overrun (out) are added.
interface spi_slave_shift_if #(
   parameter int DATA_W = spi_pkg::DATA_W_DEF
);
   logic              sclk;
   logic              ss;
   logic              mosi;
   logic              miso;
   logic              miso_oe;
   logic [DATA_W-1:0] tx_data;
   logic              tx_load;
   logic              tx_ready;
   logic [DATA_W-1:0] rx_data;
   logic              rx_valid;
   logic              busy;
`ifdef SPI_SLV_OVERRUN_EN
   logic              rx_ack;
   logic              overrun;

   modport slave (
      input  sclk, ss, mosi, tx_data, tx_load, rx_ack,
      output miso, miso_oe, tx_ready, rx_data, rx_valid, busy, overrun
   );
   modport master (
      output sclk, ss, mosi, tx_data, tx_load, rx_ack,
      input  miso, miso_oe, tx_ready, rx_data, rx_valid, busy, overrun
   );
`else
   modport slave (
      input  sclk, ss, mosi, tx_data, tx_load,
      output miso, miso_oe, tx_ready, rx_data, rx_valid, busy
   );
   modport master (
      output sclk, ss, mosi, tx_data, tx_load,
      input  miso, miso_oe, tx_ready, rx_data, rx_valid, busy
   );
`endif
endinterface

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for an asynchronous SPI line plus edge detection
// against one extra history flop.
//   PCLK, PRESET : system clock, synchronous active-high reset
//   d            : asynchronous input
//   idle_val     : value loaded into every flop on reset (line's idle level)
//   q            : synchronized level
//   edge_det     : EDGE_RISE / EDGE_FALL in the cycle q changes
// STAGES must be at least 2.
module spi_sync_edge
   import spi_pkg::*;
#(
   parameter int STAGES = 2
) (
   input  logic  PCLK,
   input  logic  PRESET,
   input  logic  d,
   input  logic  idle_val,
   output logic  q,
   output edge_t edge_det
);

   logic [STAGES-1:0] sync_q;
   logic              hist_q;

   // NOTE: registers use non-blocking assignment so every flop samples the
   // pre-edge value of its neighbour; blocking here would collapse the chain.
   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         sync_q <= {STAGES{idle_val}};
         hist_q <= idle_val;
      end else begin
         sync_q <= {sync_q[STAGES-2:0], d};
         hist_q <= sync_q[STAGES-1];
      end
   end

   assign q = sync_q[STAGES-1];

   // NOTE: default assignment first, so no path leaves edge_det unassigned
   // and no latch is inferred.
   always_comb begin
      edge_det = EDGE_NONE;
      if (q && !hist_q)
         edge_det = EDGE_RISE;
      else if (!q && hist_q)
         edge_det = EDGE_FALL;
   end

endmodule

// File: rtl/spi_slave_shift.sv
// SPI target-side shift engine. Oversamples sclk/ss/mosi on PCLK, receives
// DATA_W-bit frames from mosi and drives miso from a one-entry tx buffer.
// All four CPOL/CPHA modes, MSB- or LSB-first.
//   PCLK, PRESET      : system clock, synchronous active-high reset
//   en                : block enable (0 forces IDLE)
//   cpol, cpha, lsbfe : mode, captured at the ss fall
//   bus (slave)       : sclk, ss, mosi, miso, miso_oe, tx_data, tx_load,
//                       tx_ready, rx_data, rx_valid, busy
// Optional macro SPI_SLV_OVERRUN_EN: adds rx_ack/overrun; rx_valid becomes a
// level held until rx_ack, and a frame completing while it is set is dropped
// and flagged as overrun.
module spi_slave_shift
   import spi_pkg::*;
#(
   parameter int                DATA_W      = DATA_W_DEF,
   parameter int                SYNC_STAGES = 2,
   parameter logic [DATA_W-1:0] IDLE_TX     = DATA_W'(IDLE_TX_DEF)
) (
   input  logic             PCLK,
   input  logic             PRESET,
   input  logic             en,
   input  logic             cpol,
   input  logic             cpha,
   input  logic             lsbfe,
   spi_slave_shift_if.slave bus
);

   localparam int CNT_W = $clog2(DATA_W);

   state_t                 state;
   logic                   cpol_r, cpha_r, lsbfe_r;
   logic [CNT_W-1:0]       bit_cnt;
   logic [DATA_W-1:0]      tx_sh, tx_buf, rx_sh, rx_next;
   logic                   tx_ready, rx_valid;
   logic [DATA_W-1:0]      rx_data;
   logic [SYNC_STAGES-1:0] mosi_sync;
   logic                   sclk_q, ss_q, mosi_q;
   edge_t                  sclk_edge, ss_edge;
   logic                   sclk_moved, lead, trail, sample_edge, shift_edge;
   logic                   start, abort, run, reload, tx_accept, last_bit;
`ifdef SPI_SLV_OVERRUN_EN
   logic                   overrun;
`endif

   spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sclk_sync (
      .PCLK(PCLK), .PRESET(PRESET), .d(bus.sclk), .idle_val(cpol),
      .q(sclk_q), .edge_det(sclk_edge)
   );

   spi_sync_edge #(.STAGES(SYNC_STAGES)) u_ss_sync (
      .PCLK(PCLK), .PRESET(PRESET), .d(bus.ss), .idle_val(1'b1),
      .q(ss_q), .edge_det(ss_edge)
   );

   // mosi needs no edge detect; same depth keeps it aligned with sclk_q.
   always_ff @(posedge PCLK) begin
      if (PRESET)
         mosi_sync <= '0;
      else
         mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], bus.mosi};
   end
   assign mosi_q = mosi_sync[SYNC_STAGES-1];

   // Leading edge moves sclk away from its idle level, trailing edge returns it.
   assign sclk_moved  = (sclk_edge != EDGE_NONE);
   assign lead        = sclk_moved && (sclk_q != cpol_r);
   assign trail       = sclk_moved && (sclk_q == cpol_r);
   assign sample_edge = cpha_r ? trail : lead;
   assign shift_edge  = cpha_r ? lead  : trail;

   assign start    = (state == IDLE) && en && (ss_edge == EDGE_FALL);
   assign abort    = (state == ACTIVE) && ((ss_edge == EDGE_RISE) || !en);
   assign run      = (state == ACTIVE) && !abort;
   assign last_bit = (bit_cnt == CNT_W'(DATA_W - 1));
   assign rx_next  = lsbfe_r ? {mosi_q, rx_sh[DATA_W-1:1]}
                             : {rx_sh[DATA_W-2:0], mosi_q};

   // A shift edge with bit_cnt==0 is the first one of a frame: for cpha=1 the
   // frame's first leading edge, for cpha=0 the trailing edge after the last
   // sample. cpha=0 also needs the first bit ready at the ss fall.
   assign reload    = (start && !cpha) || (run && shift_edge && (bit_cnt == '0));
   assign tx_accept = bus.tx_load && tx_ready;

   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         state    <= IDLE;
         cpol_r   <= 1'b0;
         cpha_r   <= 1'b0;
         lsbfe_r  <= 1'b0;
         bit_cnt  <= '0;
         tx_sh    <= '0;
         tx_buf   <= '0;
         rx_sh    <= '0;
         tx_ready <= 1'b1;
         rx_data  <= '0;
         rx_valid <= 1'b0;
`ifdef SPI_SLV_OVERRUN_EN
         overrun  <= 1'b0;
`endif
      end else begin
         // A reload in the same cycle as a load takes the old (empty) buffer;
         // the accepted byte stays behind, so the accept decides tx_ready.
         if (tx_accept) begin
            tx_buf   <= bus.tx_data;
            tx_ready <= 1'b0;
         end else if (reload) begin
            tx_ready <= 1'b1;
         end

         if (reload)
            tx_sh <= tx_ready ? IDLE_TX : tx_buf;
         else if (run && shift_edge)
            tx_sh <= lsbfe_r ? (tx_sh >> 1) : (tx_sh << 1);

`ifdef SPI_SLV_OVERRUN_EN
         if (bus.rx_ack) begin
            rx_valid <= 1'b0;
            overrun  <= 1'b0;
         end
`else
         rx_valid <= 1'b0;
`endif

         case (state)
            IDLE: begin
               if (start) begin
                  state   <= ACTIVE;
                  cpol_r  <= cpol;
                  cpha_r  <= cpha;
                  lsbfe_r <= lsbfe;
                  bit_cnt <= '0;
               end
            end
            ACTIVE: begin
               if (abort) begin
                  state   <= IDLE;
                  bit_cnt <= '0;
                  rx_sh   <= '0;
               end else if (sample_edge) begin
                  rx_sh   <= rx_next;
                  bit_cnt <= last_bit ? '0 : bit_cnt + CNT_W'(1);
                  if (last_bit) begin
`ifdef SPI_SLV_OVERRUN_EN
                     if (rx_valid && !bus.rx_ack) begin
                        overrun <= 1'b1;
                     end else begin
                        rx_data  <= rx_next;
                        rx_valid <= 1'b1;
                     end
`else
                     rx_data  <= rx_next;
                     rx_valid <= 1'b1;
`endif
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.miso     = (state == ACTIVE) && (lsbfe_r ? tx_sh[0] : tx_sh[DATA_W-1]);
   assign bus.miso_oe  = ~ss_q;
   assign bus.busy     = (state == ACTIVE);
   assign bus.tx_ready = tx_ready;
   assign bus.rx_data  = rx_data;
   assign bus.rx_valid = rx_valid;
`ifdef SPI_SLV_OVERRUN_EN
   assign bus.overrun  = overrun;
`endif

endmodule

// File: tb/tb_spi_slave_shift.sv
// Directed bench for spi_slave_shift: a table of single-frame vectors across
// the four SPI modes, followed by hand-written multi-cycle sequences
// (ignored tx_load, back-to-back frames, abort, reset mid-frame and, with
// SPI_SLV_OVERRUN_EN, the overrun flag).
module tb_spi_slave_shift;

   localparam int HALF = 5;   // PCLK cycles per sclk half period

   logic PCLK = 1'b0;
   logic PRESET;
   logic en, cpol, cpha, lsbfe;

   int errors = 0;
   int checks = 0;

   always #5 PCLK = ~PCLK;

   spi_slave_shift_if #(.DATA_W(8)) bus ();

   spi_slave_shift #(
      .DATA_W(8), .SYNC_STAGES(2), .IDLE_TX(8'h00)
   ) dut (
      .PCLK(PCLK), .PRESET(PRESET), .en(en), .cpol(cpol), .cpha(cpha),
      .lsbfe(lsbfe), .bus(bus)
   );

   typedef struct {
      string      name;
      logic       cpol, cpha, lsbfe, do_load;
      logic [7:0] tx, mo, exp_miso, exp_rx;
   } vec_t;

   vec_t       vecs[4];
   logic [7:0] rx_q[$];
   logic       rv_prev   = 1'b0;
   bit         watch_busy = 1'b0;
   int         busy_low  = 0;

   // Record each new rx_valid assertion and any busy drop while watched.
   always @(posedge PCLK) begin
      #2;
      if (bus.rx_valid && !rv_prev) rx_q.push_back(bus.rx_data);
      rv_prev = bus.rx_valid;
      if (watch_busy && !bus.busy) busy_low++;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [7:0] rx_at(input int idx);
      if (idx < rx_q.size()) return rx_q[idx];
      return 'x;
   endfunction

   task automatic cyc(input int n);
      repeat (n) @(negedge PCLK);
   endtask

   task automatic load(input logic [7:0] d);
      bus.tx_data = d;
      bus.tx_load = 1'b1;
      cyc(1);
      bus.tx_load = 1'b0;
   endtask

   // One sclk half period, optionally carrying a tx_load pulse.
   task automatic half(input bit do_load, input logic [7:0] ld);
      if (do_load) begin
         load(ld);
         cyc(HALF - 1);
      end else begin
         cyc(HALF);
      end
   endtask

   task automatic set_mode(input logic p, input logic h, input logic l);
      cpol = p; cpha = h; lsbfe = l;
      bus.sclk = p;
      cyc(6);
   endtask

   task automatic ss_fall();
      bus.ss = 1'b0;
      cyc(6);
   endtask

   task automatic ss_rise();
      cyc(2);
      bus.ss = 1'b1;
      cyc(8);
   endtask

   // Master side of nbits clocks; miso is sampled on the master's sample edge.
   task automatic xfer(input logic [7:0] mo, input int nbits, input int load_at,
                       input logic [7:0] ld, output logic [7:0] mi);
      mi = '0;
      for (int i = 0; i < nbits; i++) begin
         if (!cpha) begin
            bus.mosi = lsbfe ? mo[i] : mo[7-i];
            half(i == load_at, ld);
            bus.sclk = ~cpol;
            mi[lsbfe ? i : 7-i] = bus.miso;
            half(1'b0, 8'h00);
            bus.sclk = cpol;
         end else begin
            bus.sclk = ~cpol;
            bus.mosi = lsbfe ? mo[i] : mo[7-i];
            half(i == load_at, ld);
            bus.sclk = cpol;
            mi[lsbfe ? i : 7-i] = bus.miso;
            half(1'b0, 8'h00);
         end
      end
      if (!cpha) cyc(HALF);
   endtask

   initial begin
      logic [7:0] mi;
      int         n0;

      vecs[0] = '{"mode0 msb", 1'b0, 1'b0, 1'b0, 1'b1, 8'hA5, 8'h3C, 8'hA5, 8'h3C};
      vecs[1] = '{"mode3 lsb", 1'b1, 1'b1, 1'b1, 1'b1, 8'hC3, 8'h81, 8'hC3, 8'h81};
      vecs[2] = '{"mode1 msb", 1'b0, 1'b1, 1'b0, 1'b1, 8'h5A, 8'h96, 8'h5A, 8'h96};
      vecs[3] = '{"mode2 idle", 1'b1, 1'b0, 1'b1, 1'b0, 8'hEE, 8'h7E, 8'h00, 8'h7E};

      PRESET = 1'b1; en = 1'b1; cpol = 1'b0; cpha = 1'b0; lsbfe = 1'b0;
      bus.sclk = 1'b0; bus.ss = 1'b1; bus.mosi = 1'b0;
      bus.tx_data = '0; bus.tx_load = 1'b0;
`ifdef SPI_SLV_OVERRUN_EN
      bus.rx_ack = 1'b1;   // held high so rx_valid behaves as a pulse
`endif
      cyc(3);
      check("reset miso", bus.miso, 0);
      check("reset miso_oe", bus.miso_oe, 0);
      check("reset tx_ready", bus.tx_ready, 1);
      check("reset rx_data", bus.rx_data, 0);
      check("reset rx_valid", bus.rx_valid, 0);
      check("reset busy", bus.busy, 0);
      PRESET = 1'b0;
      cyc(4);

      for (int v = 0; v < 4; v++) begin
         set_mode(vecs[v].cpol, vecs[v].cpha, vecs[v].lsbfe);
         if (vecs[v].do_load) load(vecs[v].tx);
         n0 = rx_q.size();
         ss_fall();
         check({vecs[v].name, " tx_ready after ss fall"}, bus.tx_ready,
               !(vecs[v].do_load && vecs[v].cpha));
         check({vecs[v].name, " miso_oe"}, bus.miso_oe, 1);
         check({vecs[v].name, " busy"}, bus.busy, 1);
         xfer(vecs[v].mo, 8, -1, 8'h00, mi);
         check({vecs[v].name, " miso byte"}, mi, vecs[v].exp_miso);
         ss_rise();
         check({vecs[v].name, " rx strobes"}, rx_q.size() - n0, 1);
         check({vecs[v].name, " rx_data"}, bus.rx_data, vecs[v].exp_rx);
         check({vecs[v].name, " busy after"}, bus.busy, 0);
      end

      // tx_load while the buffer is full is dropped.
      set_mode(1'b0, 1'b0, 1'b0);
      load(8'h11);
      check("load accepted tx_ready", bus.tx_ready, 0);
      load(8'h99);
      check("full load ignored tx_ready", bus.tx_ready, 0);
      ss_fall();
      xfer(8'h00, 8, -1, 8'h00, mi);
      check("full load ignored miso", mi, 8'h11);
      ss_rise();
      check("tx_ready after frame", bus.tx_ready, 1);

      // Back-to-back frames in modes 1 and 2, second byte loaded mid-frame.
      for (int m = 0; m < 2; m++) begin
         set_mode(m == 1, m == 0, 1'b0);
         load(8'h11);
         n0 = rx_q.size();
         busy_low = 0;
         ss_fall();
         watch_busy = 1'b1;
         xfer(8'hF0, 8, 3, 8'h22, mi);
         check($sformatf("b2b m%0d frame1 miso", m + 1), mi, 8'h11);
         xfer(8'h0F, 8, -1, 8'h00, mi);
         check($sformatf("b2b m%0d frame2 miso", m + 1), mi, 8'h22);
         watch_busy = 1'b0;
         ss_rise();
         check($sformatf("b2b m%0d rx strobes", m + 1), rx_q.size() - n0, 2);
         check($sformatf("b2b m%0d rx first", m + 1), rx_at(n0), 8'hF0);
         check($sformatf("b2b m%0d rx second", m + 1), rx_at(n0 + 1), 8'h0F);
         check($sformatf("b2b m%0d busy drops", m + 1), busy_low, 0);
      end

      // Abort after 5 bits, then a full frame.
      set_mode(1'b0, 1'b0, 1'b0);
      n0 = rx_q.size();
      ss_fall();
      xfer(8'hFF, 5, -1, 8'h00, mi);
      ss_rise();
      check("abort rx strobes", rx_q.size() - n0, 0);
      check("abort busy", bus.busy, 0);
      check("abort rx_data kept", bus.rx_data, 8'h0F);
      ss_fall();
      xfer(8'h5A, 8, -1, 8'h00, mi);
      ss_rise();
      check("after abort rx strobes", rx_q.size() - n0, 1);
      check("after abort rx_data", bus.rx_data, 8'h5A);

      // PRESET mid-frame.
      load(8'h77);
      ss_fall();
      xfer(8'hAA, 4, -1, 8'h00, mi);
      PRESET = 1'b1;
      cyc(1);
      check("midreset miso", bus.miso, 0);
      check("midreset miso_oe", bus.miso_oe, 0);
      check("midreset tx_ready", bus.tx_ready, 1);
      check("midreset rx_data", bus.rx_data, 0);
      check("midreset rx_valid", bus.rx_valid, 0);
      check("midreset busy", bus.busy, 0);
      PRESET = 1'b0;
      bus.ss = 1'b1;
      cyc(10);
      check("post reset busy", bus.busy, 0);
      ss_fall();
      xfer(8'hC7, 8, -1, 8'h00, mi);
      ss_rise();
      check("post reset rx_data", bus.rx_data, 8'hC7);

`ifdef SPI_SLV_OVERRUN_EN
      bus.rx_ack = 1'b0;
      ss_fall();
      xfer(8'h12, 8, -1, 8'h00, mi);
      ss_rise();
      check("ovr first rx_valid", bus.rx_valid, 1);
      check("ovr first overrun", bus.overrun, 0);
      ss_fall();
      xfer(8'h34, 8, -1, 8'h00, mi);
      ss_rise();
      check("ovr second overrun", bus.overrun, 1);
      check("ovr second rx_data", bus.rx_data, 8'h12);
      check("ovr second rx_valid", bus.rx_valid, 1);
      bus.rx_ack = 1'b1;
      cyc(1);
      bus.rx_ack = 1'b0;
      cyc(1);
      check("ovr ack rx_valid", bus.rx_valid, 0);
      check("ovr ack overrun", bus.overrun, 0);
      bus.rx_ack = 1'b1;
      cyc(2);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/spi_slave_shift.md
Name: spi_slave_shift

Overview:
SPI target-side shift engine, the slave end of the SPI master core's shift register. It oversamples the external SCLK, SS and MOSI lines on the system clock, receives 8-bit frames from MOSI, and drives MISO from a one-entry transmit buffer. It supports all four CPOL/CPHA modes and MSB- or LSB-first bit order, and presents received bytes to the register interface with a valid strobe.

Parameters:
DATA_W, 8, frame width in bits (bit counter sized clog2(DATA_W))
SYNC_STAGES, 2, synchronizer flops on sclk/ss/mosi (min 2)
IDLE_TX, 8'h00, byte shifted out when the tx buffer is empty at frame start

Ports:
PCLK  in  1  system clock; all logic on rising edge
PRESET  in  1  reset; synchronous, active-high
en  in  1  block enable; 0 forces IDLE and ignores bus activity
cpol  in  1  SCLK idle level
cpha  in  1  0: sample on leading edge; 1: sample on trailing edge
lsbfe  in  1  1: LSB first; 0: MSB first
sclk  in  1  SPI clock from master (asynchronous)
ss  in  1  slave select, active-low (asynchronous)
mosi  in  1  serial data from master (asynchronous)
miso  out  1  serial data to master
miso_oe  out  1  MISO output enable (1 while selected)
tx_data  in  DATA_W  byte to transmit
tx_load  in  1  write strobe for tx_data
tx_ready  out  1  tx buffer empty, load accepted
rx_data  out  DATA_W  last complete received byte
rx_valid  out  1  new rx_data strobe
busy  out  1  frame in progress

Behaviour:
- Reset (PRESET=1 at a PCLK edge): miso=0, miso_oe=0, tx_ready=1, rx_data=0, rx_valid=0, busy=0; bit counter=0; synchronizers loaded with the idle values ss=1 and sclk=cpol.
- Sync: sclk, ss and mosi each pass through SYNC_STAGES flops. Edges are detected against one extra history flop. Required ratio: PCLK >= 4x sclk. The master must leave >= SYNC_STAGES+2 PCLK cycles between the ss fall and the first sclk edge.
- Edge definitions: leading edge = transition from cpol to ~cpol; trailing edge = the opposite transition. Sample edge is the leading edge if cpha=0, the trailing edge if cpha=1. Shift edge is the other edge.
- cpol, cpha and lsbfe are captured at the ss fall. Changes during the frame are ignored until the next ss fall.
- FSM states:
  - IDLE: ss_sync=1 or en=0. Synced ss fall with en=1 moves to ACTIVE.
  - ACTIVE: shifting. Synced ss rise moves to IDLE.
  - There is no separate DONE state; a frame completes inside ACTIVE.
- Tx reload at each frame boundary moves the buffer (or IDLE_TX if empty) into the shift register and sets tx_ready=1:
  - cpha=0: at the ss fall, and at the shift edge following the 8th sample.
  - cpha=1: at the first shift edge of each frame (bit counter=0).
- miso presents the current shift bit: MSB if lsbfe=0, LSB if lsbfe=1. It advances on each non-reload shift edge. miso_oe=~ss_sync. miso=0 in IDLE.
- Rx: on each sample edge, the synced mosi is shifted in by lsbfe order and the counter increments. On the 8th sample:
  - rx_data is updated and rx_valid pulses for exactly 1 PCLK, in the cycle after the edge is detected.
  - The counter wraps to 0 and busy stays 1 while ss is low (back-to-back frames).
- busy=1 from the ss fall until the ss rise.
- tx_load with tx_ready=1: buffer written, tx_ready=0 on the next cycle. tx_load with tx_ready=0 is ignored (no overwrite).
- tx_load in the same cycle as a reload: the reload consumes the old buffer content, and the new byte is written to the buffer (tx_ready ends at 0).
- ss rise mid-frame: abort. Counter cleared, partial rx discarded (no rx_valid), and a tx byte already consumed is lost. The tx buffer is kept.
- en=0 mid-frame behaves as an abort. PRESET mid-frame forces reset values on the next edge.

Optional Feature:
SPI_SLV_OVERRUN_EN:
- Defined: adds input rx_ack and output overrun (sticky, reset 0).
  - rx_valid becomes a level that holds until rx_ack.
  - A completing frame while rx_valid=1 sets overrun=1 and leaves rx_data unchanged.
  - overrun clears on rx_ack.
  - rx_ack and frame completion in the same cycle: new data is accepted, rx_valid stays 1, no overrun.
- Undefined: the ports are absent and rx_valid is a 1-cycle pulse that overwrites rx_data unconditionally.

Decomposition:
- Package spi_pkg: DATA_W default, edge-type encoding, FSM state encoding (IDLE, ACTIVE), IDLE_TX constant.
- One sub-module spi_sync_edge: N-stage synchronizer plus rise/fall detect, instantiated for sclk and ss; mosi uses synchronizer only.

Test Plan:
- Mode 0, lsbfe=0, tx_data=8'hA5 loaded, master sends 8'h3C -> MISO bits 1,0,1,0,0,1,0,1; rx_data=8'h3C with a single rx_valid; tx_ready=1 after the ss fall.
- Mode 3, lsbfe=1, tx_data=8'hC3, master sends 8'h81 -> MISO bits sampled LSB first equal 8'hC3; rx_data=8'h81.
- Modes 1 and 2, two back-to-back frames with ss held low, tx 8'h11 then 8'h22 (second loaded mid-frame 1) -> master receives 8'h11, 8'h22; two rx_valid strobes; busy stays 1 throughout.
- No tx_load before the frame -> MISO shifts 8'h00 (IDLE_TX); tx_load during tx_ready=0 is ignored.
- ss rise after 5 bits, then a new full frame of 8'h5A -> no rx_valid for the aborted frame; rx_data=8'h5A after the second frame; PRESET pulse mid-frame returns all outputs to reset values.
- SPI_SLV_OVERRUN_EN: two frames without rx_ack -> overrun=1, rx_data holds the first byte; rx_ack clears rx_valid and overrun.
